// File: rtl/uart_tx_lfsr.sv
// -----------------------------------------------------------------------------
// uart_tx_lfsr
//
// Byte-oriented UART transmitter with a free-running 8-bit LFSR test-pattern
// generator. Bytes arrive over a valid/ready handshake and are serialised onto
// an idle-high line: start bit, 8 data bits LSB first, optional even parity
// bit, and a stop bit. Each bit lasts CLKS_PER_BIT clocks.
//
// The LFSR (x^8+x^6+x^5+x^4+1, Fibonacci, shifting left) advances on every
// clock edge outside reset. It is exposed on lfsr_data so it can be looped
// back into tx_data for link bring-up.
//
// Build option:
//   UART_TX_PARITY_EN  - when defined, an even-parity bit is sent between
//                        data bit 7 and the stop bit (11-bit frame).
//                        When undefined, the frame is plain 8N1 (10 bits).
//
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   tx_data[7:0]   in   byte to send, sampled only at handshake
//   tx_data_valid  in   tx_data is valid
//   tx_data_ready  out  transmitter idle and able to accept a byte (registered)
//   UART_TX        out  serial line, idle high (registered)
//   lfsr_data[7:0] out  current LFSR state
// -----------------------------------------------------------------------------
module uart_tx_lfsr #(
  parameter int         CLK_FREQ     = 50_000_000,
  parameter int         BAUD_RATE    = 115200,
  parameter int         CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter logic [7:0] LFSR_SEED    = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       UART_TX,
  output logic [7:0] lfsr_data
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  // An all-zero seed would lock the LFSR, so it is replaced.
  localparam logic [7:0]       SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  // Next LFSR value: taps 7,5,4,3 fed back into bit 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

`ifdef UART_TX_PARITY_EN
  // Even parity over a byte: 1 when the byte has an odd number of ones.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       idx_r, idx_s;
  logic [7:0]       shreg_r, shreg_s;
  logic             tx_r, tx_s;
  logic             ready_r, ready_s;
  logic [7:0]       lfsr_r;
  logic             baud_done_s;

  assign UART_TX       = tx_r;
  assign tx_data_ready = ready_r;
  assign lfsr_data     = lfsr_r;

  // Free-running pattern generator.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= SEED_EFF;
    end else begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  // Next-state, counters and next output values. Outputs are derived from the
  // next state so the registered line changes on the same edge as the state.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    shreg_s     = shreg_r;
    tx_s        = 1'b1;
    ready_s     = 1'b0;
    baud_done_s = (cnt_r == CNT_LAST);

    case (state_r)
      ST_IDLE: begin
        // ready_r guarantees the first post-reset edge cannot accept a byte.
        if (tx_data_valid && ready_r) begin
          state_s = ST_START;
          shreg_s = tx_data;
          cnt_s   = CNT_ZERO;
          idx_s   = 3'd0;
        end else begin
          cnt_s   = CNT_ZERO;
          idx_s   = 3'd0;
        end
      end
      ST_START: begin
        if (baud_done_s) begin
          state_s = ST_DATA;
          cnt_s   = CNT_ZERO;
          idx_s   = 3'd0;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (baud_done_s) begin
          cnt_s = CNT_ZERO;
          if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_s = ST_PARITY;
`else
            state_s = ST_STOP;
`endif
            idx_s   = 3'd0;
          end else begin
            idx_s   = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_done_s) begin
          state_s = ST_STOP;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (baud_done_s) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        idx_s   = 3'd0;
      end
    endcase

    case (state_s)
      ST_IDLE: begin
        tx_s    = 1'b1;
        ready_s = 1'b1;
      end
      ST_START: begin
        tx_s    = 1'b0;
      end
      ST_DATA: begin
        tx_s    = shreg_s[idx_s];
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_s    = even_parity(shreg_s);
      end
`endif
      ST_STOP: begin
        tx_s    = 1'b1;
      end
      default: begin
        tx_s    = 1'b1;
        ready_s = 1'b0;
      end
    endcase
  end

  // Transmitter state and registered outputs; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 3'd0;
      shreg_r <= 8'h00;
      tx_r    <= 1'b1;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shreg_r <= shreg_s;
      tx_r    <= tx_s;
      ready_r <= ready_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_lfsr.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_lfsr - directed self-checking bench for uart_tx_lfsr
// (CLK_FREQ=1000, BAUD_RATE=100 -> 10 clocks per bit). Outputs are sampled
// on the falling clock edge; inputs are driven there as well.
// -----------------------------------------------------------------------------
module tb_uart_tx_lfsr;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int FLEN = FBITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_byte;
  logic       use_lfsr;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;
  logic       UART_TX;
  logic [7:0] lfsr_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  assign tx_data = use_lfsr ? lfsr_data : tx_byte;

  uart_tx_lfsr #(
    .CLK_FREQ  (1000),
    .BAUD_RATE (100),
    .LFSR_SEED (8'h01)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .UART_TX       (UART_TX),
    .lfsr_data     (lfsr_data)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp accept edges.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected line level at frame bit position pos.
  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    else if (pos <= 8) return b[pos-1];
`ifdef UART_TX_PARITY_EN
    else if (pos == 9) return ^b;
`endif
    else return 1'b1;
  endfunction

  task automatic wait_ready();
    bit seen = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (tx_data_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Send one byte and check line and ready on every cycle of the frame.
  task automatic send_check(input logic [7:0] b);
    wait_ready();
    tx_byte       = b;
    tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data_valid = 1'b0;
    for (int i = 0; i < FLEN; i++) begin
      check($sformatf("frame_%02h_c%0d", b, i), {30'd0, tx_data_ready, UART_TX},
            {30'd0, 1'b0, frame_bit(b, i / CPB)});
      @(negedge clk);
    end
    check("ready_back", {31'd0, tx_data_ready}, 32'd1);
    check("idle_line", {31'd0, UART_TX}, 32'd1);
  endtask

  // Decode one frame by mid-bit sampling.
  task automatic recv_frame(output logic [7:0] got);
    bit   seen = 1'b0;
    logic s_start, s_stop;
    got = 8'h00;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (UART_TX == 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("rx_timeout", 32'd0, 32'd1);
    end else begin
      repeat (5) @(negedge clk);
      s_start = UART_TX;
      for (int j = 0; j < 8; j++) begin
        repeat (CPB) @(negedge clk);
        got[j] = UART_TX;
      end
`ifdef UART_TX_PARITY_EN
      repeat (CPB) @(negedge clk);
      check("rx_parity", {31'd0, UART_TX}, {31'd0, ^got});
`endif
      repeat (CPB) @(negedge clk);
      s_stop = UART_TX;
      check("rx_start", {31'd0, s_start}, 32'd0);
      check("rx_stop", {31'd0, s_stop}, 32'd1);
    end
  endtask

  task automatic count_lows(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (UART_TX == 1'b0) lows++;
    end
  endtask

  logic [7:0] seq [6];
  logic [7:0] exp_b [5];
  int         acc_cyc [5];
  int         acc;
  logic       rdy_d;
  int         zeros, first_ret, lows;
  logic [7:0] got_b;

  initial begin
    seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    rst = 1'b1;
    tx_data_valid = 1'b1;   // valid during reset must not be accepted
    tx_byte = 8'hFF;
    use_lfsr = 1'b0;

    // Reset held for 10 edges
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_tx", {31'd0, UART_TX}, 32'd1);
      check("rst_ready", {31'd0, tx_data_ready}, 32'd0);
    end
    check("rst_lfsr", {24'd0, lfsr_data}, {24'd0, seq[0]});
    rst = 1'b0;
    tx_data_valid = 1'b0;

    // Ready one edge after release; LFSR sequence
    @(negedge clk);
    check("ready_rise", {31'd0, tx_data_ready}, 32'd1);
    check("no_accept_in_rst", {31'd0, UART_TX}, 32'd1);
    check("lfsr_1", {24'd0, lfsr_data}, {24'd0, seq[1]});
    for (int i = 2; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("lfsr_%0d", i), {24'd0, lfsr_data}, {24'd0, seq[i]});
    end
    zeros = 0;
    first_ret = 0;
    for (int n = 6; n <= 255; n++) begin
      @(negedge clk);
      if (lfsr_data == 8'h00) zeros++;
      if (lfsr_data == 8'h01 && first_ret == 0) first_ret = n;
    end
    check("lfsr_period", first_ret, 32'd255);
    check("lfsr_no_zero", zeros, 32'd0);

    // Directed single frames
    send_check(8'hA5);
    send_check(8'h07);
    send_check(8'h03);

    // Back-to-back frames from LFSR, valid = registered copy of ready
    use_lfsr = 1'b1;
    acc = 0;
    rdy_d = 1'b0;
    fork
      begin
        for (int t = 0; t < 900; t++) begin
          @(negedge clk);
          tx_data_valid = rdy_d;
          rdy_d = tx_data_ready;
          if (tx_data_valid && tx_data_ready) begin
            if (acc < 5) begin
              exp_b[acc]   = lfsr_data;
              acc_cyc[acc] = cyc;
            end
            acc++;
          end
          if (acc >= 5 && !tx_data_valid) break;
        end
        tx_data_valid = 1'b0;
      end
      begin
        for (int f = 0; f < 5; f++) begin
          recv_frame(got_b);
          check($sformatf("b2b_byte%0d", f), {24'd0, got_b}, {24'd0, exp_b[f]});
        end
      end
    join
    check("b2b_count", acc, 32'd5);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("b2b_gap%0d", i),
            {31'd0, (acc_cyc[i] - acc_cyc[i-1]) >= (FLEN + 1)}, 32'd1);
    end
    count_lows(3 * FLEN, lows);
    check("b2b_no_extra", lows, 32'd0);
    use_lfsr = 1'b0;

    // Reset during data bit 3 of 8'h00
    wait_ready();
    tx_byte = 8'h00;
    tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data_valid = 1'b0;
    for (int i = 0; i < 4 * CPB + 4; i++) @(negedge clk);
    check("mid_bit3_low", {31'd0, UART_TX}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", {31'd0, UART_TX}, 32'd1);
    check("abort_ready", {31'd0, tx_data_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_rise", {31'd0, tx_data_ready}, 32'd1);
    count_lows(FLEN + 20, lows);
    check("abort_no_resume", lows, 32'd0);
    send_check(8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
